// File: rtl/uart_receiver_r.sv
// Oversampling UART receiver: start-bit detect, mid-bit sampling, LSB-first shift,
// stop-bit check with single-cycle rx_valid / frame_error strobes.
module uart_receiver_r #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_rate_signal,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_error_q, frame_error_d;
  logic                   rx_busy_q, rx_busy_d;
  logic                   rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      rx_busy_q     <= 1'b0;
    end else begin
      sync1_q       <= rx;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      rx_busy_q     <= rx_busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Start detection is edge-level on rx_s, independent of baud ticks
        if (!rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (baud_rate_signal) begin
          if (tick_cnt_q == TICK_HALF) begin
            if (!rx_s) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d    = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (baud_rate_signal) begin
          if (tick_cnt_q == TICK_LAST) begin
            shift_d                = shift_q >> 1;
            shift_d[DATA_BITS-1]   = rx_s;
            tick_cnt_d             = '0;
            bit_cnt_d              = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BIT_LAST) state_d = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (baud_rate_signal) begin
          if (tick_cnt_q == TICK_LAST) begin
            // Return to IDLE at mid-stop so a following start edge is not missed
            if (rx_s) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              frame_error_d = 1'b1;
            end
            state_d    = IDLE;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign rx_busy     = rx_busy_q;

endmodule

// File: tb/tb_uart_receiver_r.sv
// Directed bench for uart_receiver_r: OVERSAMPLE=16, DATA_BITS=8, one baud tick every 4 clk.
module tb_uart_receiver_r;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_rate_signal = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       rx_busy;

  logic       tick_en = 1'b1;
  int         n_checks = 0;
  int         n_pass = 0;

  int         valid_hi = 0;
  int         ferr_hi = 0;
  int         both_hi = 0;
  logic [7:0] rx_log[$];

  uart_receiver_r #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .baud_rate_signal (baud_rate_signal),
    .rx               (rx),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .frame_error      (frame_error),
    .rx_busy          (rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph = ph + 1;
      baud_rate_signal = tick_en && (ph % 4 == 0);
    end
  end

  // Every high cycle is counted, so a strobe wider than one clk shows up as an extra count
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_hi <= valid_hi + 1;
      rx_log.push_back(rx_data);
    end
    if (frame_error) ferr_hi <= ferr_hi + 1;
    if (rx_valid && frame_error) both_hi <= both_hi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int pause_bit);
    int v0;
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == pause_bit) begin
        wait_clk(16);
        tick_en = 1'b0;
        v0 = valid_hi + ferr_hi;
        wait_clk(50);
        chk("pause_busy", rx_busy, 1);
        wait_clk(50);
        chk("pause_no_strobe", valid_hi + ferr_hi, v0);
        tick_en = 1'b1;
        wait_clk(48);
      end else begin
        wait_clk(BIT_CLK);
      end
    end
    if (stop_b) begin
      rx = 1'b1;
      wait_clk(BIT_CLK);
    end else begin
      // Low only through the mid-stop sample so the line recovers afterwards
      rx = 1'b0;
      wait_clk(40);
      rx = 1'b1;
      wait_clk(24);
    end
  endtask

  initial begin
    int v0, f0, q0;
    logic [7:0] b5a;

    wait_clk(5);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_frame_error", frame_error, 0);
    chk("reset_rx_busy", rx_busy, 0);
    rst_n = 1'b1;
    wait_clk(10);

    // 1: single good frame
    v0 = valid_hi; f0 = ferr_hi;
    send_frame(8'hA5, 1'b1, -1);
    wait_clk(8);
    chk("t1_valid_cnt", valid_hi - v0, 1);
    chk("t1_ferr_cnt", ferr_hi - f0, 0);
    chk("t1_rx_data", rx_data, 8'hA5);
    chk("t1_busy_idle", rx_busy, 0);
    $display("txn 1: frame 0xA5 -> rx_data=0x%02h", rx_data);

    // 2: back-to-back frames with no idle gap
    v0 = valid_hi; q0 = rx_log.size();
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_clk(8);
    chk("t2_valid_cnt", valid_hi - v0, 2);
    chk("t2_first_byte", (rx_log.size() > q0) ? rx_log[q0] : 8'hEE, 8'h00);
    chk("t2_second_byte", (rx_log.size() > q0 + 1) ? rx_log[q0+1] : 8'hEE, 8'hFF);
    chk("t2_rx_data", rx_data, 8'hFF);
    $display("txn 2: frames 0x00,0xFF -> rx_data=0x%02h", rx_data);

    // 3: glitch shorter than half a bit is a false start
    v0 = valid_hi; f0 = ferr_hi;
    rx = 1'b0;
    wait_clk(8);
    chk("t3_busy_start", rx_busy, 1);
    wait_clk(8);
    rx = 1'b1;
    wait_clk(48);
    chk("t3_busy_idle", rx_busy, 0);
    chk("t3_no_valid", valid_hi - v0, 0);
    chk("t3_no_ferr", ferr_hi - f0, 0);
    $display("txn 3: false start -> rx_busy=%0b", rx_busy);

    // 4: bad stop bit
    v0 = valid_hi; f0 = ferr_hi;
    send_frame(8'h3C, 1'b0, -1);
    wait_clk(BIT_CLK);
    chk("t4_ferr_cnt", ferr_hi - f0, 1);
    chk("t4_no_valid", valid_hi - v0, 0);
    chk("t4_rx_data_held", rx_data, 8'hFF);
    chk("t4_busy_idle", rx_busy, 0);
    $display("txn 4: frame 0x3C bad stop -> rx_data=0x%02h", rx_data);

    // 5: reset during data bit 4, then a clean frame
    b5a = 8'h5A;
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = b5a[i];
      wait_clk(BIT_CLK);
    end
    rx = b5a[4];
    wait_clk(32);
    rst_n = 1'b0;
    wait_clk(3);
    chk("t5_rst_rx_data", rx_data, 0);
    chk("t5_rst_rx_valid", rx_valid, 0);
    chk("t5_rst_ferr", frame_error, 0);
    chk("t5_rst_busy", rx_busy, 0);
    rx = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(BIT_CLK);
    v0 = valid_hi; f0 = ferr_hi;
    send_frame(8'h81, 1'b1, -1);
    wait_clk(8);
    chk("t5_valid_cnt", valid_hi - v0, 1);
    chk("t5_rx_data", rx_data, 8'h81);
    $display("txn 5: reset mid-frame, then 0x81 -> rx_data=0x%02h", rx_data);

    // 6: ticks stalled for 100 clk inside data bit 3
    v0 = valid_hi; f0 = ferr_hi;
    send_frame(8'hC3, 1'b1, 3);
    wait_clk(8);
    chk("t6_valid_cnt", valid_hi - v0, 1);
    chk("t6_ferr_cnt", ferr_hi - f0, 0);
    chk("t6_rx_data", rx_data, 8'hC3);
    chk("never_both_strobes", both_hi, 0);
    $display("txn 6: stalled ticks, frame 0xC3 -> rx_data=0x%02h", rx_data);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
